// File: rtl/xnor_bist_checker.sv
// Built-in self-test checker for a 2-input XNOR gate. It sweeps {x,y} through 00,01,10,11
// for NUM_PASSES passes, samples z after SETTLE_CYCLES, and reports the mismatches it found.
module xnor_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             x,
    output logic             y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic             fail_valid
);

    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SET_W-1:0]  settle_cnt, settle_cnt_next;
    logic [1:0]        vec_idx, vec_idx_next;
    logic [PASS_W-1:0] pass_cnt, pass_cnt_next;
    logic              x_next, y_next, busy_next, done_next, pass_next;
    logic [CNT_W-1:0]  err_count_next;
    logic [1:0]        fail_vec_next;
    logic              fail_valid_next;

    logic settle_end;
    logic last_vec;
    logic mismatch;

    assign settle_end = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign last_vec   = (vec_idx == 2'd3) && (pass_cnt == PASS_W'(NUM_PASSES - 1));
    assign mismatch   = (z != ~(x ^ y));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_end) state_next = SAMPLE;
            SAMPLE:  state_next = last_vec ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values; every output is registered below
    always_comb begin
        settle_cnt_next = settle_cnt;
        vec_idx_next    = vec_idx;
        pass_cnt_next   = pass_cnt;
        x_next          = x;
        y_next          = y;
        busy_next       = busy;
        done_next       = 1'b0;
        pass_next       = pass;
        err_count_next  = err_count;
        fail_vec_next   = fail_vec;
        fail_valid_next = fail_valid;

        case (state)
            IDLE: begin
                x_next    = 1'b0;
                y_next    = 1'b0;
                busy_next = 1'b0;
                if (start) begin
                    err_count_next  = '0;
                    pass_next       = 1'b0;
                    fail_vec_next   = 2'b00;
                    fail_valid_next = 1'b0;
                    vec_idx_next    = 2'd0;
                    pass_cnt_next   = '0;
                    settle_cnt_next = '0;
                    busy_next       = 1'b1;
                end
            end
            SETTLE: begin
                settle_cnt_next = settle_end ? '0 : settle_cnt + SET_W'(1);
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_count != '1) err_count_next = err_count + CNT_W'(1);
                    if (!fail_valid) begin
                        fail_vec_next   = {x, y};
                        fail_valid_next = 1'b1;
                    end
                end
                if (!last_vec) begin
                    vec_idx_next    = vec_idx + 2'd1;
                    if (vec_idx == 2'd3) pass_cnt_next = pass_cnt + PASS_W'(1);
                    x_next          = vec_idx_next[1];
                    y_next          = vec_idx_next[0];
                    settle_cnt_next = '0;
                end else begin
                    done_next = 1'b1;
                    busy_next = 1'b0;
                    x_next    = 1'b0;
                    y_next    = 1'b0;
                    pass_next = (err_count_next == '0);
                end
            end
            DONE: begin
                x_next    = 1'b0;
                y_next    = 1'b0;
                busy_next = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            vec_idx    <= 2'd0;
            pass_cnt   <= '0;
            x          <= 1'b0;
            y          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 2'b00;
            fail_valid <= 1'b0;
        end else begin
            settle_cnt <= settle_cnt_next;
            vec_idx    <= vec_idx_next;
            pass_cnt   <= pass_cnt_next;
            x          <= x_next;
            y          <= y_next;
            busy       <= busy_next;
            done       <= done_next;
            pass       <= pass_next;
            err_count  <= err_count_next;
            fail_vec   <= fail_vec_next;
            fail_valid <= fail_valid_next;
        end
    end

endmodule

// File: tb/tb_xnor_bist_checker.sv
// Testbench for xnor_bist_checker. Several gate models drive z, and each run is checked against
// hand-computed results.
module tb_xnor_bist_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance a: default parameters, selectable gate model
    logic       start_a, x_a, y_a, z_a, busy_a, done_a, pass_a, fvalid_a;
    logic [7:0] err_a;
    logic [1:0] fv_a;
    int         mode;

    // Instance b: three passes, 3-bit saturating counter, XOR gate
    logic       start_b, x_b, y_b, z_b, busy_b, done_b, pass_b, fvalid_b;
    logic [2:0] err_b;
    logic [1:0] fv_b;

    xnor_bist_checker dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .x(x_a), .y(y_a), .z(z_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_vec(fv_a), .fail_valid(fvalid_a)
    );

    xnor_bist_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .x(x_b), .y(y_b), .z(z_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_vec(fv_b), .fail_valid(fvalid_b)
    );

    // Gate models: 0 xnor, 1 stuck-0, 2 and, 3 xor, 4 nand, 5 stuck-1
    always_comb begin
        case (mode)
            1:       z_a = 1'b0;
            2:       z_a = x_a & y_a;
            3:       z_a = x_a ^ y_a;
            4:       z_a = ~(x_a & y_a);
            5:       z_a = 1'b1;
            default: z_a = ~(x_a ^ y_a);
        endcase
    end
    assign z_b = x_b ^ y_b;

    // Selected-instance view for the shared run task
    int         sel;
    logic       c_x, c_y, c_busy, c_done, c_pass, c_fvalid;
    logic [7:0] c_err;
    logic [1:0] c_fv;
    always_comb begin
        if (sel == 0) begin
            c_x = x_a; c_y = y_a; c_busy = busy_a; c_done = done_a; c_pass = pass_a;
            c_fvalid = fvalid_a; c_err = err_a; c_fv = fv_a;
        end else begin
            c_x = x_b; c_y = y_b; c_busy = busy_b; c_done = done_b; c_pass = pass_b;
            c_fvalid = fvalid_b; c_err = {5'b0, err_b}; c_fv = fv_b;
        end
    end

    int done_cnt_a = 0;
    int done_cnt_b = 0;
    always @(posedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    sel;
        int    mode;
        int    cycles;
        int    e_err;
        int    e_fv;
        int    e_fvalid;
        int    e_pass;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dcnt(input int s);
        return (s == 0) ? done_cnt_a : done_cnt_b;
    endfunction

    // Run one full sweep, checking the vector on every cycle and the results at the end
    task automatic run(input vec_t v);
        int d0;
        sel  = v.sel;
        mode = v.mode;
        d0   = dcnt(v.sel);
        if (v.sel == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        chk({v.name, " cleared err"}, 32'(c_err), 0);
        chk({v.name, " cleared fvalid"}, 32'(c_fvalid), 0);
        chk({v.name, " cleared pass"}, 32'(c_pass), 0);
        for (int k = 0; k < v.cycles; k++) begin
            chk({v.name, " xy"}, 32'({c_x, c_y}), 32'((k / 3) % 4));
            chk({v.name, " busy"}, 32'(c_busy), 1);
            chk({v.name, " done early"}, 32'(c_done), 0);
            tick();
        end
        chk({v.name, " done"}, 32'(c_done), 1);
        chk({v.name, " busy end"}, 32'(c_busy), 0);
        chk({v.name, " xy end"}, 32'({c_x, c_y}), 0);
        chk({v.name, " err_count"}, 32'(c_err), 32'(v.e_err));
        chk({v.name, " fail_vec"}, 32'(c_fv), 32'(v.e_fv));
        chk({v.name, " fail_valid"}, 32'(c_fvalid), 32'(v.e_fvalid));
        chk({v.name, " pass"}, 32'(c_pass), 32'(v.e_pass));
        tick();
        chk({v.name, " done pulse"}, 32'(c_done), 0);
        chk({v.name, " done count"}, 32'(dcnt(v.sel) - d0), 1);
        chk({v.name, " err held"}, 32'(c_err), 32'(v.e_err));
        chk({v.name, " pass held"}, 32'(c_pass), 32'(v.e_pass));
    endtask

    initial begin
        int d0;
        tbl[0] = '{"xnor",    0, 0, 12, 0, 0, 0, 1};
        tbl[1] = '{"stuck0",  0, 1, 12, 2, 0, 1, 0};
        tbl[2] = '{"and",     0, 2, 12, 1, 0, 1, 0};
        tbl[3] = '{"xor",     0, 3, 12, 4, 0, 1, 0};
        tbl[4] = '{"nand",    0, 4, 12, 3, 1, 1, 0};
        tbl[5] = '{"stuck1",  0, 5, 12, 2, 1, 1, 0};
        tbl[6] = '{"xor3sat", 1, 3, 36, 7, 0, 1, 0};

        sel = 0; mode = 0;
        start_a = 1'b0; start_b = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        chk("reset busy", 32'(busy_a), 0);
        chk("reset done", 32'(done_a), 0);
        chk("reset pass", 32'(pass_a), 0);
        chk("reset xy", 32'({x_a, y_a}), 0);
        chk("reset err", 32'(err_a), 0);
        chk("reset fail_vec", 32'(fv_a), 0);
        chk("reset fvalid", 32'(fvalid_a), 0);
        chk("reset b busy", 32'(busy_b), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run(tbl[i]);
            tick();
        end

        // Extra start pulses at E5 and during DONE are ignored
        sel = 0; mode = 2;
        d0 = done_cnt_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("restart ignored busy", 32'(busy_a), 1);
        for (int k = 0; k < 7; k++) tick();
        chk("restart done", 32'(done_a), 1);
        chk("restart err", 32'(err_a), 1);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("done-start busy", 32'(busy_a), 0);
        tick();
        chk("done-start no run", 32'(busy_a), 0);
        chk("done-start err held", 32'(err_a), 1);
        chk("done-start fail_vec", 32'(fv_a), 0);
        chk("done-start fvalid", 32'(fvalid_a), 1);
        chk("done-start pass", 32'(pass_a), 0);
        for (int k = 0; k < 5; k++) tick();
        chk("single done pulse", 32'(done_cnt_a - d0), 1);

        // start held high: next run begins from the first IDLE cycle after DONE
        mode = 0;
        start_a = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) tick();
        chk("held done", 32'(done_a), 1);
        tick();
        chk("held idle gap", 32'(busy_a), 0);
        tick();
        chk("held restart busy", 32'(busy_a), 1);
        start_a = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("held second done", 32'(done_a), 1);
        chk("held second pass", 32'(pass_a), 1);
        tick(); tick();

        // Reset at E7 aborts the run with no done pulse
        mode = 1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("pre-reset err", 32'(err_a), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset busy", 32'(busy_a), 0);
        chk("midreset xy", 32'({x_a, y_a}), 0);
        chk("midreset err", 32'(err_a), 0);
        chk("midreset fvalid", 32'(fvalid_a), 0);
        d0 = done_cnt_a;
        for (int k = 0; k < 15; k++) tick();
        chk("midreset no done", 32'(done_cnt_a - d0), 0);
        chk("midreset idle", 32'(busy_a), 0);
        run(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xnor_bist_checker.md
Name: xnor_bist_checker

Overview:
Synthesizable stimulus/response checker for a 2-input XNOR gate under test: the hardware counterpart of the simulation stimulus bench.
- On `start`, drives every input vector `{x,y}` in the order 00, 01, 10, 11, for `NUM_PASSES` sweeps.
- Samples the gate output `z` after a settle time and compares it with the expected XNOR value.
- Reports the mismatch count, the first failing vector, and pass/fail.
- Sits beside `xnor_db` (or any 2-in/1-out gate with the same pinout) in on-chip self-test.

Parameters:
- `SETTLE_CYCLES`, default 2: cycles a vector is held before `z` is sampled; legal range is 1 or more.
- `NUM_PASSES`, default 1: number of full 4-vector sweeps per run; legal range is 1 or more.
- `CNT_W`, default 8: width of `err_count`.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  synchronous reset, active-low.
- `start`  input  1  run request; sampled only in `IDLE`.
- `x`  output  1  gate-under-test input A (registered).
- `y`  output  1  gate-under-test input B (registered).
- `z`  input  1  gate-under-test output.
- `busy`  output  1  high while a run is in progress.
- `done`  output  1  one-cycle pulse at end of run.
- `pass`  output  1  1 = last run had zero mismatches; held until next start.
- `err_count`  output  CNT_W  mismatches in last run, saturating.
- `fail_vec`  output  2  first failing `{x,y}` of last run.
- `fail_valid`  output  1  `fail_vec` holds a captured failure.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values (`rst_n`=0 at a clock edge):
  - state = `IDLE`.
  - `x`=0, `y`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_vec`=00, `fail_valid`=0.
  - Internal vector index, pass counter and settle counter = 0.
  - Applies mid-run too: the run is aborted and no `done` pulse is issued.
- FSM states: `IDLE`, `SETTLE`, `SAMPLE`, `DONE`.
- `IDLE`:
  - `x`,`y` = 00, `busy`=0.
  - `start`=1 at edge E0: clear `err_count`, `pass`, `fail_valid`, `fail_vec`; load vector 0 (`x`=0, `y`=0); `busy`=1; go to `SETTLE` with settle counter 0.
- `SETTLE`:
  - Counter increments each edge.
  - On the edge where the counter reaches `SETTLE_CYCLES`-1, go to `SAMPLE`.
- `SAMPLE` (one cycle):
  - Expected value = ~(x ^ y).
  - At the edge ending this cycle, if `z` != expected:
    - `err_count` += 1, saturating at 2^CNT_W-1.
    - If `fail_valid`=0, capture `fail_vec`={x,y} and set `fail_valid`=1.
  - At the same edge, if vectors remain: advance to the next vector, where index wraps 3→0 and the pass counter increments; load the new `x`,`y`; go to `SETTLE`.
  - Otherwise go to `DONE`.
- `DONE` (one cycle):
  - `done`=1, `busy`=0.
  - `pass` = (`err_count`==0), registered on entry and held afterwards.
  - `x`,`y` return to 00.
  - Next state is `IDLE` unconditionally; `start` is ignored during `DONE`.
- Timing, with L = `SETTLE_CYCLES`+1:
  - Vector n (n=0..4*NUM_PASSES-1) is driven from edge E0+n*L.
  - `z` is sampled at edge E0+(n+1)*L.
  - `done` is high in the cycle after edge E0+4*NUM_PASSES*L.
  - Defaults: 12 cycles, so `done` is high after E12.
- `start` while `busy`=1 or in `DONE`: ignored, no restart.
- `start` held high continuously: a new run begins from the first `IDLE` cycle after `DONE`.
- `err_count`, `fail_vec`, `fail_valid` and `pass` hold their values after the run until the next accepted `start`.
- `z` is treated as asynchronous-free: the block requires it to be stable before the `SAMPLE` edge, with no internal synchronizer.

Test Plan:
- Good XNOR model, defaults; `start` pulse at E0 → vectors 00,01,10,11 at E0/E3/E6/E9; `done` after E12; `pass`=1, `err_count`=0, `fail_valid`=0.
- z stuck at 0 → mismatches on 00 and 11; `err_count`=2, `fail_vec`=00, `fail_valid`=1, `pass`=0.
- AND gate as DUT → only 00 mismatches; `err_count`=1, `fail_vec`=00, `pass`=0.
- XOR gate, `NUM_PASSES`=3, `CNT_W`=3 → 12 mismatches saturate at `err_count`=7; `done` after E36; `pass`=0.
- `start` pulsed again at E5 and at the `DONE` cycle → no restart; single `done` pulse; results unchanged.
- `rst_n`=0 at E7 mid-run → next cycle `busy`=0, `x`=`y`=0, `err_count`=0, no `done` pulse; a fresh `start` runs a full 12-cycle sweep correctly.
